// File: rtl/fft_out_reorder.sv
// -----------------------------------------------------------------------------
// fft_out_reorder
//
// Reader-side companion to the radix-2 FFT core. The core emits each result
// frame in bit-reversed bin order. Each sample is written straight to its
// natural bin address in one bank of a ping-pong buffer. A full bank is then
// replayed in natural order 0..N_POINTS-1 on a valid/ready stream.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   res_i, res_q        FFT result sample (signed I/Q)
//   res_valid, res_sof  sample present / first sample of a frame
//   res_ready           write bank available
//   out_i, out_q        natural-order bin data
//   out_index           bin number of the current output word
//   out_valid/out_ready output handshake
//   out_sop, out_eop    high with bin 0 / bin N_POINTS-1
//   overflow            sticky: sample presented while res_ready=0
//   frame_err           sticky: res_sof arrived with a partial frame pending
//   flag_clr            synchronous clear of the sticky flags (a set wins)
// -----------------------------------------------------------------------------
module fft_out_reorder #(
   parameter int SAMPLE_WORD_LENGTH = 8,
   parameter int N_POINTS           = 16
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic signed [SAMPLE_WORD_LENGTH-1:0]   res_i,
   input  logic signed [SAMPLE_WORD_LENGTH-1:0]   res_q,
   input  logic                                   res_valid,
   input  logic                                   res_sof,
   output logic                                   res_ready,
   output logic signed [SAMPLE_WORD_LENGTH-1:0]   out_i,
   output logic signed [SAMPLE_WORD_LENGTH-1:0]   out_q,
   output logic [$clog2(N_POINTS)-1:0]            out_index,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic                                   out_sop,
   output logic                                   out_eop,
   output logic                                   overflow,
   output logic                                   frame_err,
   input  logic                                   flag_clr
);

   localparam int ADDR_WIDTH = $clog2(N_POINTS);
   localparam int WORD       = 2 * SAMPLE_WORD_LENGTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N_POINTS - 1);

   typedef enum logic {IDLE, STREAM} rd_state_t;

   function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH-1:0] r;
      for (int b = 0; b < ADDR_WIDTH; b++) r[b] = a[ADDR_WIDTH-1-b];
      return r;
   endfunction

   logic [WORD-1:0]       mem [0:1][0:N_POINTS-1];
   logic [1:0]            bank_full;
   logic                  run;          // holds res_ready low until after reset release
   logic                  wr_bank;
   logic [ADDR_WIDTH-1:0] wr_cnt;

   rd_state_t             state, state_nxt;
   logic                  rd_bank, rd_bank_nxt;
   logic [ADDR_WIDTH-1:0] rd_cnt, rd_cnt_nxt;
   logic                  valid_nxt;
   logic                  ld;
   logic                  ld_bank;
   logic [ADDR_WIDTH-1:0] ld_idx;
   logic                  rd_clr;
   logic [WORD-1:0]       rd_word;

   // ---------------- write side ----------------
   logic                  wr_acc, wr_restart, wr_last;
   logic [ADDR_WIDTH-1:0] wr_addr;

   assign res_ready  = run & ~bank_full[wr_bank];
   assign wr_acc     = res_valid & res_ready;
   // A new frame start over a partial frame restarts the bank at bin 0.
   assign wr_restart = wr_acc & res_sof & (wr_cnt != '0);
   assign wr_addr    = wr_restart ? '0 : bitrev(wr_cnt);
   assign wr_last    = wr_acc & ~wr_restart & (wr_cnt == LAST_IDX);

   // NOTE: the sample store has no reset; bank_full gates every read, so stale
   // contents are never emitted and the array can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_bank][wr_addr] <= {res_i, res_q};
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of process ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run     <= 1'b0;
         wr_bank <= 1'b0;
         wr_cnt  <= '0;
      end else begin
         run <= 1'b1;
         if (wr_acc) begin
            if (wr_restart) begin
               wr_cnt <= ADDR_WIDTH'(1);
            end else if (wr_last) begin
               wr_cnt  <= '0;
               wr_bank <= ~wr_bank;
            end else begin
               wr_cnt <= wr_cnt + 1'b1;
            end
         end
      end
   end

   // The writer only sets the bank it fills and the reader only clears the
   // bank it drains; these are always different banks.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bank_full <= 2'b00;
      end else begin
         bank_full <= (bank_full | {wr_last & wr_bank, wr_last & ~wr_bank})
                    & ~{rd_clr & rd_bank, rd_clr & ~rd_bank};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         overflow  <= (res_valid & ~res_ready) | (overflow & ~flag_clr);
         frame_err <= wr_restart | (frame_err & ~flag_clr);
      end
   end

   // ---------------- read side ----------------
   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt   = state;
      rd_cnt_nxt  = rd_cnt;
      rd_bank_nxt = rd_bank;
      valid_nxt   = out_valid;
      ld          = 1'b0;
      ld_bank     = rd_bank;
      ld_idx      = '0;
      rd_clr      = 1'b0;
      case (state)
         IDLE: begin
            if (bank_full[rd_bank]) begin
               ld         = 1'b1;
               valid_nxt  = 1'b1;
               rd_cnt_nxt = '0;
               state_nxt  = STREAM;
            end
         end
         STREAM: begin
            if (out_ready) begin
               if (rd_cnt != LAST_IDX) begin
                  ld         = 1'b1;
                  ld_idx     = rd_cnt + 1'b1;
                  rd_cnt_nxt = rd_cnt + 1'b1;
               end else begin
                  rd_clr      = 1'b1;
                  rd_bank_nxt = ~rd_bank;
                  rd_cnt_nxt  = '0;
                  if (bank_full[~rd_bank]) begin
                     // Back-to-back frame: next bank's bin 0 with no bubble.
                     ld      = 1'b1;
                     ld_bank = ~rd_bank;
                  end else begin
                     valid_nxt = 1'b0;
                     state_nxt = IDLE;
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign rd_word = mem[ld_bank][ld_idx];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         rd_bank   <= 1'b0;
         rd_cnt    <= '0;
         out_valid <= 1'b0;
         out_i     <= '0;
         out_q     <= '0;
      end else begin
         state     <= state_nxt;
         rd_bank   <= rd_bank_nxt;
         rd_cnt    <= rd_cnt_nxt;
         out_valid <= valid_nxt;
         if (ld) begin
            out_i <= rd_word[WORD-1 -: SAMPLE_WORD_LENGTH];
            out_q <= rd_word[SAMPLE_WORD_LENGTH-1:0];
         end
      end
   end

   assign out_index = rd_cnt;
   assign out_sop   = out_valid & (rd_cnt == '0);
   assign out_eop   = out_valid & (rd_cnt == LAST_IDX);

endmodule

// File: tb/tb_fft_out_reorder.sv
// -----------------------------------------------------------------------------
// tb_fft_out_reorder
//
// Bench for fft_out_reorder. The reference model treats a frame as an array of
// bins indexed by bin number. The n-th accepted sample of a frame belongs to bin
// bitrev(n). Completed frames wait in a queue. At most two frames can be
// pending (stored, not yet fully read). Every output word is compared with the
// front frame of the queue.
// -----------------------------------------------------------------------------
module tb_fft_out_reorder;
   localparam int W = 8;
   localparam int N = 16;
   localparam int AW = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic signed [W-1:0]  res_i, res_q;
   logic                 res_valid, res_sof, res_ready;
   logic signed [W-1:0]  out_i, out_q;
   logic [AW-1:0]        out_index;
   logic                 out_valid, out_ready, out_sop, out_eop;
   logic                 overflow, frame_err, flag_clr;

   fft_out_reorder #(.SAMPLE_WORD_LENGTH(W), .N_POINTS(N)) dut (
      .clk(clk), .rst(rst),
      .res_i(res_i), .res_q(res_q), .res_valid(res_valid), .res_sof(res_sof),
      .res_ready(res_ready),
      .out_i(out_i), .out_q(out_q), .out_index(out_index), .out_valid(out_valid),
      .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
      .overflow(overflow), .frame_err(frame_err), .flag_clr(flag_clr)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [N*2*W-1:0] frames[$];
   logic [N*2*W-1:0] part;
   int               wcnt, ridx, frames_out;
   bit               m_en, m_ovf, m_ferr;
   bit               hold_pend;
   logic [2*W+AW-1:0] hold_word;

   function automatic int bitrev(input int a);
      int r = 0;
      for (int b = 0; b < AW; b++) r = r * 2 + ((a >> b) & 1);
      return r;
   endfunction

   task automatic model_reset();
      frames.delete();
      part = '0; wcnt = 0; ridx = 0;
      m_en = 0; m_ovf = 0; m_ferr = 0; hold_pend = 0;
   endtask

   // Check current outputs against the model, advance the model over the
   // coming rising edge, then return at the following falling edge.
   task automatic step();
      bit rdy, ovf_set, fe_set;
      logic [2*W-1:0] exp_word;
      check("res_ready", res_ready, m_en && frames.size() < 2);
      check("overflow", overflow, m_ovf);
      check("frame_err", frame_err, m_ferr);
      if (hold_pend) begin
         check("hold_valid", out_valid, 1);
         check("hold_word", {out_i, out_q, out_index}, hold_word);
      end
      if (out_valid) begin
         if (frames.size() == 0) begin
            check("spurious_valid", out_valid, 0);
         end else begin
            exp_word = frames[0][ridx*2*W +: 2*W];
            check("out_data", {out_i, out_q}, exp_word);
            check("out_index", out_index, ridx);
            check("out_sop", out_sop, ridx == 0);
            check("out_eop", out_eop, ridx == N - 1);
         end
      end else begin
         check("marks_idle", {out_sop, out_eop}, 0);
      end
      hold_pend = out_valid && !out_ready;
      hold_word = {out_i, out_q, out_index};

      rdy     = m_en && frames.size() < 2;
      ovf_set = res_valid && !rdy;
      fe_set  = 0;
      if (out_valid && out_ready && frames.size() > 0) begin
         ridx++;
         if (ridx == N) begin
            void'(frames.pop_front());
            ridx = 0;
            frames_out++;
         end
      end
      if (res_valid && rdy) begin
         if (res_sof && wcnt != 0) begin
            fe_set = 1;
            wcnt = 0;
         end
         part[bitrev(wcnt)*2*W +: 2*W] = {res_i, res_q};
         wcnt++;
         if (wcnt == N) begin
            frames.push_back(part);
            wcnt = 0;
         end
      end
      m_ovf  = ovf_set || (m_ovf && !flag_clr);
      m_ferr = fe_set || (m_ferr && !flag_clr);
      m_en   = 1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic [W-1:0] i, input logic [W-1:0] q, input bit sof);
      res_i = i; res_q = q; res_valid = 1'b1; res_sof = sof;
      step();
      res_valid = 1'b0; res_sof = 1'b0;
   endtask

   task automatic send_rand_frame();
      for (int n = 0; n < N; n++) send(W'($urandom), W'($urandom), n == 0);
   endtask

   task automatic clear_flags();
      flag_clr = 1'b1; step(); flag_clr = 1'b0;
   endtask

   // mode 0: always ready, 1: ready pattern 1,0,0,..., 2: random
   task automatic drain(input int mode);
      int c = 0;
      res_valid = 1'b0;
      while (frames.size() != 0 && c < 400) begin
         case (mode)
            0: out_ready = 1'b1;
            1: out_ready = (c % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         step();
         c++;
      end
      if (frames.size() != 0) check("drain_timeout", frames.size(), 0);
      out_ready = 1'b1;
      step();
   endtask

   task automatic do_reset();
      res_valid = 1'b0; res_sof = 1'b0; flag_clr = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("rst_outputs", {out_valid, out_sop, out_eop, out_index, overflow, frame_err, res_ready}, 0);
      check("rst_data", {out_i, out_q}, 0);
      model_reset();
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int fo, c;
      rst = 1'b0; res_i = '0; res_q = '0; res_valid = 1'b0; res_sof = 1'b0;
      out_ready = 1'b1; flag_clr = 1'b0; frames_out = 0;
      model_reset();
      @(negedge clk);
      #1;
      check("reset_state", {out_valid, out_sop, out_eop, out_index, overflow, frame_err, res_ready, out_i, out_q}, 0);
      @(negedge clk);
      rst = 1'b1;
      step();
      step();

      // 1: reorder one frame, latency of bin 0
      out_ready = 1'b1;
      for (int n = 0; n < N; n++) send(W'(bitrev(n)), W'(-bitrev(n)), n == 0);
      check("latency_k", out_valid, 0);
      step();
      check("latency_k1", {out_valid, out_sop, out_index, out_i, out_q}, {1'b1, 1'b1, 4'd0, 8'd0, 8'd0});
      drain(0);
      check("t1_flags", {overflow, frame_err}, 0);

      // 2: same frame with stalling consumer
      for (int n = 0; n < N; n++) send(W'(bitrev(n)), W'(-bitrev(n)), n == 0);
      drain(1);

      // 3: two frames stored, third dropped, then back-to-back replay
      out_ready = 1'b0;
      send_rand_frame();
      send_rand_frame();
      for (int n = 0; n < 3; n++) send(W'($urandom), W'($urandom), n == 0);
      check("t3_ready_low", res_ready, 0);
      check("t3_overflow", overflow, 1);
      out_ready = 1'b1;
      for (int k = 0; k < 2 * N; k++) begin
         check("t3_no_gap", out_valid, 1);
         step();
      end
      check("t3_done", out_valid, 0);
      clear_flags();

      // 4: partial frame interrupted by a new frame start
      fo = frames_out;
      for (int n = 0; n < 5; n++) send(W'($urandom), W'($urandom), n == 0);
      send_rand_frame();
      check("t4_frame_err", frame_err, 1);
      drain(0);
      check("t4_frames", frames_out - fo, 1);
      clear_flags();

      // 5: reset mid-write and mid-stream
      for (int n = 0; n < 7; n++) send(W'($urandom), W'($urandom), n == 0);
      do_reset();
      for (int k = 0; k < 20; k++) step();
      send_rand_frame();
      c = 0;
      while (ridx != 9 && c < 100) begin step(); c++; end
      check("t5_reach_bin9", out_index, 9);
      do_reset();
      for (int k = 0; k < 20; k++) step();
      check("t5_no_residual", out_valid, 0);

      // 6: flag_clr loses against a simultaneous overflow
      out_ready = 1'b0;
      send_rand_frame();
      send_rand_frame();
      send(W'($urandom), W'($urandom), 1'b1);
      check("t6_ovf_set", overflow, 1);
      flag_clr = 1'b1;
      send(W'($urandom), W'($urandom), 1'b0);
      check("t6_set_wins", overflow, 1);
      step();
      flag_clr = 1'b0;
      check("t6_cleared", overflow, 0);
      drain(0);

      // randomized traffic
      for (int k = 0; k < 1500; k++) begin
         res_valid = ($urandom_range(0, 3) != 0);
         res_sof   = (wcnt == 0) || ($urandom_range(0, 49) == 0);
         res_i     = W'($urandom);
         res_q     = W'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         flag_clr  = ($urandom_range(0, 31) == 0);
         step();
      end
      res_valid = 1'b0; res_sof = 1'b0; flag_clr = 1'b0;
      drain(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
